pc_sequencer: RTL and testbench

- Next-PC generator and fetch sequencer: drives the Din/PCWrite side of the 16-bit PC register, reading back its Out and TopOut.
- Computes sequential, branch, jump, call and return targets.
- Holds a small return-address stack.
- Handshakes with instruction memory for each fetch.
- Runs on the rising edge of CLK. The PC register captures on the falling edge of the same cycle, so PCDin and PCWrite must be stable for the whole cycle.

---
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC generator and fetch sequencer for a 16-bit PC register.
// Registered PCDin/PCWrite stay stable for the whole cycle the PC register captures on.
module pc_sequencer #(
  parameter int          PC_INC    = 2,
  parameter int          RAS_DEPTH = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Run,
  input  logic [15:0] PCOut,
  input  logic [2:0]  PCTop,
  output logic [15:0] PCDin,
  output logic        PCWrite,
  output logic        IMemReq,
  input  logic        IMemAck,
  input  logic        Stall,
  input  logic        Seq,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Call,
  input  logic        Ret,
  input  logic        Halt,
  input  logic        BrTaken,
  input  logic [15:0] BrTarget,
  input  logic [12:0] JAddr,
  output logic        RasErr,
  output logic [1:0]  State
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     pcdin_q, pcdin_d;
  logic            pcwr_q, pcwr_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     ras_q [RAS_DEPTH];
  logic            push;
  logic [15:0]     seq_pc;
  logic [15:0]     jmp_pc;
  logic [PW-1:0]   top_idx;
  logic [15:0]     pop_v;

  assign seq_pc  = PCOut + 16'(PC_INC);
  assign jmp_pc  = {PCTop, JAddr};
  assign top_idx = ptr_q - 1'b1;
  assign pop_v   = ras_q[top_idx];

  always_comb begin
    state_d = state_q;
    pcdin_d = pcdin_q;
    pcwr_d  = 1'b0;
    req_d   = 1'b0;
    err_d   = err_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Run) begin
          pcdin_d = RESET_PC;
          pcwr_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      // first FETCH cycle is the PC write cycle, so the request starts one later
      S_FETCH: begin
        req_d = 1'b1;
        if (req_q && IMemAck) begin
          req_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!Stall) begin
          if (Halt) begin
            state_d = S_HALT;
          end else if (Ret) begin
            pcwr_d  = 1'b1;
            state_d = S_FETCH;
            if (cnt_q == '0) begin
              pcdin_d = 16'h0000;
              err_d   = 1'b1;
            end else begin
              pcdin_d = pop_v;
              ptr_d   = top_idx;
              cnt_d   = cnt_q - 1'b1;
            end
          end else if (Call) begin
            push    = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            pcdin_d = jmp_pc;
            pcwr_d  = 1'b1;
            state_d = S_FETCH;
            // full stack: the slot at ptr holds the oldest entry
            if (cnt_q == CW'(RAS_DEPTH)) begin
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (Jump) begin
            pcdin_d = jmp_pc;
            pcwr_d  = 1'b1;
            state_d = S_FETCH;
          end else if (Branch) begin
            pcdin_d = BrTaken ? BrTarget : seq_pc;
            pcwr_d  = 1'b1;
            state_d = S_FETCH;
          end else if (Seq) begin
            pcdin_d = seq_pc;
            pcwr_d  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (Run) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pcdin_q <= 16'h0000;
      pcwr_q  <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pcdin_q <= pcdin_d;
      pcwr_q  <= pcwr_d;
      req_q   <= req_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      ras_q[ptr_q] <= seq_pc;
    end
  end

  assign PCDin   = pcdin_q;
  assign PCWrite = pcwr_q;
  assign IMemReq = req_q;
  assign RasErr  = err_q;
  assign State   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a behavioural PC register
// and a queue-based return-stack model.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Run = 1'b0;
  logic [15:0] PCOut;
  logic [2:0]  PCTop;
  logic [15:0] PCDin;
  logic        PCWrite;
  logic        IMemReq;
  logic        IMemAck = 1'b0;
  logic        Stall = 1'b0;
  logic        Seq = 1'b0, Branch = 1'b0, Jump = 1'b0;
  logic        Call = 1'b0, Ret = 1'b0, Halt = 1'b0;
  logic        BrTaken = 1'b0;
  logic [15:0] BrTarget = 16'h0;
  logic [12:0] JAddr = 13'h0;
  logic        RasErr;
  logic [1:0]  State;

  localparam logic [5:0] C_SEQ = 6'b000001;
  localparam logic [5:0] C_BR  = 6'b000010;
  localparam logic [5:0] C_JMP = 6'b000100;
  localparam logic [5:0] C_CAL = 6'b001000;
  localparam logic [5:0] C_RET = 6'b010000;
  localparam logic [5:0] C_HLT = 6'b100000;

  pc_sequencer #(.PC_INC(2), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .Run(Run),
    .PCOut(PCOut), .PCTop(PCTop), .PCDin(PCDin), .PCWrite(PCWrite),
    .IMemReq(IMemReq), .IMemAck(IMemAck), .Stall(Stall),
    .Seq(Seq), .Branch(Branch), .Jump(Jump), .Call(Call), .Ret(Ret),
    .Halt(Halt), .BrTaken(BrTaken), .BrTarget(BrTarget), .JAddr(JAddr),
    .RasErr(RasErr), .State(State)
  );

  always #5 CLK = ~CLK;

  // PC register model: captures on the falling edge
  logic [15:0] pcreg = 16'h1234;
  assign PCOut = pcreg;
  assign PCTop = pcreg[15:13];
  always @(negedge CLK) if (PCWrite === 1'b1) pcreg <= PCDin;

  logic [15:0] expq [$];
  logic [15:0] ras [$];
  bit          merr = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && PCWrite === 1'b1) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got PCDin %h expected no write", PCDin);
        end else begin
          check("pcdin", PCDin, expq.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(logic [5:0] c, logic tk, logic [15:0] tgt, logic [12:0] ja);
    {Halt, Ret, Call, Jump, Branch, Seq} = c;
    BrTaken = tk;
    BrTarget = tgt;
    JAddr = ja;
  endtask

  task automatic issue(logic [5:0] c, logic tk, logic [15:0] tgt, logic [12:0] ja);
    logic [15:0] sv, jv, e;
    bit wr;
    sv = pcreg + 16'd2;
    jv = {pcreg[15:13], ja};
    e = 16'h0;
    wr = 1'b1;
    if (c[5]) wr = 1'b0;
    else if (c[4]) begin
      if (ras.size() == 0) begin
        e = 16'h0;
        merr = 1'b1;
      end else e = ras.pop_back();
    end else if (c[3]) begin
      if (ras.size() == 4) begin
        void'(ras.pop_front());
        merr = 1'b1;
      end
      ras.push_back(sv);
      e = jv;
    end else if (c[2]) e = jv;
    else if (c[1]) e = tk ? tgt : sv;
    else if (c[0]) e = sv;
    else wr = 1'b0;
    if (wr) expq.push_back(e);
    drive(c, tk, tgt, ja);
    @(posedge CLK);
    #1;
    drive(6'b0, 1'b0, 16'h0, 13'h0);
    check("ras_err", RasErr, merr);
    check("state_after_cmd", State, c[5] ? 2'd3 : (wr ? 2'd1 : 2'd2));
  endtask

  task automatic do_fetch(int dly);
    int t;
    t = 0;
    while (IMemReq !== 1'b1 && t < 20) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("fetch_req", IMemReq, 1'b1);
    repeat (dly) begin
      @(posedge CLK);
      #1;
    end
    check("req_held", IMemReq, 1'b1);
    IMemAck = 1'b1;
    @(posedge CLK);
    #1;
    IMemAck = 1'b0;
    check("exec_state", State, 2'd2);
    check("req_drop", IMemReq, 1'b0);
  endtask

  task automatic run_pulse(bit from_idle);
    if (from_idle) expq.push_back(16'h0000);
    Run = 1'b1;
    @(posedge CLK);
    #1;
    Run = 1'b0;
    check("run_state", State, 2'd1);
    check("run_write", PCWrite, from_idle);
    check("run_req_low", IMemReq, 1'b0);
  endtask

  task automatic stall_cycle(logic [5:0] c);
    Stall = 1'b1;
    drive(c, 1'b1, 16'h5550, 13'h0AAA);
    @(posedge CLK);
    #1;
    Stall = 1'b0;
    drive(6'b0, 1'b0, 16'h0, 13'h0);
    check("stall_state", State, 2'd2);
  endtask

  logic [15:0] saved;
  logic [31:0] r;

  initial begin
    #1;
    check("rst_state", State, 2'd0);
    check("rst_pcdin", PCDin, 16'h0);
    check("rst_pcwrite", PCWrite, 1'b0);
    check("rst_req", IMemReq, 1'b0);
    check("rst_raserr", RasErr, 1'b0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    run_pulse(1'b1);
    @(posedge CLK);
    #1;
    check("req_rise", IMemReq, 1'b1);
    check("write_one_cycle", PCWrite, 1'b0);
    do_fetch(3);
    issue(C_SEQ, 0, 0, 0);
    do_fetch(0);
    issue(C_BR, 1, 16'hFFFE, 0);
    do_fetch(1);
    issue(C_SEQ, 0, 0, 0);
    do_fetch(0);
    issue(C_BR, 1, 16'hA010, 0);
    do_fetch(2);
    issue(C_JMP, 0, 0, 13'h0123);
    do_fetch(0);
    issue(C_BR, 1, 16'h4000, 0);
    do_fetch(0);
    issue(C_BR, 0, 16'h1110, 0);
    do_fetch(0);
    issue(C_BR, 1, 16'h2000, 0);
    do_fetch(0);
    issue(C_CAL, 0, 0, 13'h0100);
    do_fetch(1);
    issue(C_RET, 0, 0, 0);
    do_fetch(0);
    for (int i = 0; i < 5; i++) begin
      issue(C_CAL, 0, 0, 13'(16'h0200 + i * 16'h20));
      do_fetch(0);
    end
    for (int i = 0; i < 5; i++) begin
      issue(C_RET, 0, 0, 0);
      do_fetch(0);
    end
    for (int i = 0; i < 3; i++) stall_cycle(C_SEQ | C_JMP);
    issue(C_SEQ | C_JMP, 0, 0, 13'h0777);
    do_fetch(0);
    issue(C_HLT | C_SEQ, 0, 0, 0);
    saved = pcreg;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("halt_state", State, 2'd3);
      check("halt_req", IMemReq, 1'b0);
    end
    run_pulse(1'b0);
    do_fetch(1);
    check("resume_pc", PCOut, saved);
    issue(C_SEQ, 0, 0, 0);
    @(posedge CLK);
    #1;
    check("mid_fetch_req", IMemReq, 1'b1);
    RST_N = 1'b0;
    #1;
    check("arst_state", State, 2'd0);
    check("arst_req", IMemReq, 1'b0);
    check("arst_raserr", RasErr, 1'b0);
    ras.delete();
    merr = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    run_pulse(1'b1);
    do_fetch(0);
    issue(C_RET, 0, 0, 0);
    do_fetch(0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      for (int k = 0; k < int'(r[1:0]) % 3; k++) stall_cycle(6'(r[7:3]));
      if (r[10:8] == 3'd0) issue(6'b0, 0, 0, 0);
      r = $urandom;
      saved = r[15:0] & 16'hFFFE;
      issue(6'($urandom_range(1, 31)), r[16], saved, 13'(r[31:19]));
      do_fetch(int'($urandom_range(0, 3)));
    end
    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
